// File: rtl/capture_sequencer.sv
// Frame capture sequencer: gates camera BRAM writes, detects complete frames and hands off to the matcher.
// Optional collection timeout is compiled in with `define CAPTURE_SEQ_TIMEOUT_EN.
module capture_sequencer #(
    parameter int NUM_CAMS       = 2,
    parameter int FRAME_WORDS    = 12800,
    parameter int ADDR_W         = 17,
    parameter int TIMEOUT_CYCLES = 4000000
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       pacing_in,
    input  logic                       single_shot_in,
    input  logic [NUM_CAMS-1:0]        cam_wea_in,
    input  logic [NUM_CAMS*ADDR_W-1:0] cam_addr_in,
    input  logic                       frame_done_in,
    output logic [NUM_CAMS-1:0]        cam_we_out,
    output logic                       new_frame_out,
    output logic                       reading_out,
    output logic [1:0]                 state_out,
    output logic [15:0]                frame_count_out,
    output logic                       timeout_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PROCESS = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    state_t              state_q, state_d;
    logic [NUM_CAMS-1:0] started_q, started_d;
    logic [NUM_CAMS-1:0] finished_q, finished_d;
    logic                single_q, single_d;
    logic                new_frame_q, new_frame_d;
    logic                reading_q, reading_d;
    logic [15:0]         count_q, count_d;
    logic                all_fin;
    logic                timeout_hit;

    assign all_fin = &finished_q;

`ifdef CAPTURE_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign timeout_hit = (state_q == S_COLLECT) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside COLLECT, so every entry starts a fresh window.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == S_COLLECT && !timeout_hit && !all_fin) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo  = ^TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            started_q   <= '0;
            finished_q  <= '0;
            single_q    <= 1'b0;
            new_frame_q <= 1'b0;
            reading_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            started_q   <= started_d;
            finished_q  <= finished_d;
            single_q    <= single_d;
            new_frame_q <= new_frame_d;
            reading_q   <= reading_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        started_d   = started_q;
        finished_d  = finished_q;
        single_d    = single_q;
        new_frame_d = 1'b0;
        reading_d   = reading_q;
        count_d     = count_q;
        case (state_q)
            S_IDLE: begin
                if (pacing_in || single_shot_in) begin
                    state_d  = S_COLLECT;
                    single_d = single_shot_in && !pacing_in;
                end
            end
            S_COLLECT: begin
                // finished[] keys off the registered started[], so address 0 alone never completes a camera.
                for (int k = 0; k < NUM_CAMS; k++) begin
                    if (cam_wea_in[k] && cam_addr_in[k*ADDR_W +: ADDR_W] == '0) begin
                        started_d[k] = 1'b1;
                    end
                    if (started_q[k] && cam_wea_in[k] && cam_addr_in[k*ADDR_W +: ADDR_W] == LAST_ADDR) begin
                        finished_d[k] = 1'b1;
                    end
                end
                if (all_fin) begin
                    state_d     = S_PROCESS;
                    new_frame_d = 1'b1;
                    reading_d   = 1'b0;
                    started_d   = '0;
                    finished_d  = '0;
                end else if (timeout_hit) begin
                    started_d  = '0;
                    finished_d = '0;
                end
            end
            S_PROCESS: begin
                if (frame_done_in) begin
                    state_d   = S_DONE;
                    reading_d = 1'b1;
                    count_d   = count_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = (pacing_in && !single_q) ? S_COLLECT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cam_we_out      = (state_q == S_COLLECT) ? cam_wea_in : '0;
        new_frame_out   = new_frame_q;
        reading_out     = reading_q;
        state_out       = state_q;
        frame_count_out = count_q;
        timeout_out     = timeout_hit;
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: a 2-camera and a 4-camera instance with 16-word frames.
module tb_capture_sequencer;

    localparam int AW = 17;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst2, pacing2, ss2, done2;
    logic [1:0]    wea2;
    logic [2*AW-1:0] addr2;
    logic [1:0]    we2;
    logic          new2, read2, to2;
    logic [1:0]    state2;
    logic [15:0]   cnt2;

    logic          rst4, pacing4, ss4, done4;
    logic [3:0]    wea4;
    logic [4*AW-1:0] addr4;
    logic [3:0]    we4;
    logic          new4, read4, to4;
    logic [1:0]    state4;
    logic [15:0]   cnt4;

    int errors = 0;
    int checks = 0;

    capture_sequencer #(.NUM_CAMS(2), .FRAME_WORDS(16), .ADDR_W(AW), .TIMEOUT_CYCLES(50)) u_dut2 (
        .clk_in(clk), .rst_in(rst2), .pacing_in(pacing2), .single_shot_in(ss2),
        .cam_wea_in(wea2), .cam_addr_in(addr2), .frame_done_in(done2),
        .cam_we_out(we2), .new_frame_out(new2), .reading_out(read2),
        .state_out(state2), .frame_count_out(cnt2), .timeout_out(to2)
    );

    capture_sequencer #(.NUM_CAMS(4), .FRAME_WORDS(16), .ADDR_W(AW), .TIMEOUT_CYCLES(4000000)) u_dut4 (
        .clk_in(clk), .rst_in(rst4), .pacing_in(pacing4), .single_shot_in(ss4),
        .cam_wea_in(wea4), .cam_addr_in(addr4), .frame_done_in(done4),
        .cam_we_out(we4), .new_frame_out(new4), .reading_out(read4),
        .state_out(state4), .frame_count_out(cnt4), .timeout_out(to4)
    );

    typedef struct {
        logic       rst;
        logic       pacing;
        logic       ss;
        logic       done;
        logic [1:0] wea;
        logic [1:0] e_state;
        logic [1:0] e_we;
        logic       e_new;
        logic       e_read;
        logic [15:0] e_cnt;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set2(input logic [1:0] we, input int a0, input int a1);
        wea2  = we;
        addr2 = {AW'(a1), AW'(a0)};
    endtask

    vec_t vecs[11];

    initial begin
        rst2 = 1'b1; pacing2 = 1'b0; ss2 = 1'b0; done2 = 1'b0; set2(2'b00, 0, 0);
        rst4 = 1'b1; pacing4 = 1'b0; ss4 = 1'b0; done4 = 1'b0; wea4 = '0; addr4 = '0;
        tick();
        tick();
        rst4 = 1'b0;

        // rst pacing ss done wea | state we new read cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 2'b00, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'd0, 2'b00, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0, 2'b00, 1'b0, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'd1, 2'b11, 1'b0, 1'b0, 16'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 2'd1, 2'b10, 1'b0, 1'b0, 16'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'd0, 2'b00, 1'b0, 1'b0, 16'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 2'b00, 1'b0, 1'b0, 16'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'd1, 2'b00, 1'b0, 1'b0, 16'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'd1, 2'b01, 1'b0, 1'b0, 16'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'd0, 2'b00, 1'b0, 1'b0, 16'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 2'b00, 1'b0, 1'b0, 16'd0};

        for (int v = 0; v < 11; v++) begin
            rst2 = vecs[v].rst; pacing2 = vecs[v].pacing; ss2 = vecs[v].ss; done2 = vecs[v].done;
            set2(vecs[v].wea, 3, 3);
            tick();
            chk($sformatf("vec%0d state", v), 32'(state2), 32'(vecs[v].e_state));
            chk($sformatf("vec%0d cam_we", v), 32'(we2), 32'(vecs[v].e_we));
            chk($sformatf("vec%0d new_frame", v), 32'(new2), 32'(vecs[v].e_new));
            chk($sformatf("vec%0d reading", v), 32'(read2), 32'(vecs[v].e_read));
            chk($sformatf("vec%0d frame_count", v), 32'(cnt2), 32'(vecs[v].e_cnt));
        end
        ss2 = 1'b0; done2 = 1'b0;

        // Timeout window: camera 0 stays idle, camera 1 completes early.
        pacing2 = 1'b1;
        tick();
        for (int c = 1; c <= 50; c++) begin
            if (c <= 16) set2(2'b10, 0, c - 1);
            else         set2(2'b00, 0, 0);
            #1;
            chk($sformatf("timeout cyc%0d", c), 32'(to2), 32'(TMO_EN && c == 50));
            chk($sformatf("timeout state cyc%0d", c), 32'(state2), 32'd1);
            tick();
        end
        set2(2'b00, 0, 0);
        chk("timeout after pulse", 32'(to2), 32'd0);
        for (int i = 0; i < 16; i++) begin
            set2(2'b01, i, 0);
            tick();
        end
        set2(2'b00, 0, 0);
        tick();
        chk("timeout flags cleared", 32'(state2), TMO_EN ? 32'd1 : 32'd2);
        rst2 = 1'b1; pacing2 = 1'b0;
        tick();
        rst2 = 1'b0;

        // Aligned sweep with pacing.
        pacing2 = 1'b1;
        tick();
        chk("sweep enter collect", 32'(state2), 32'd1);
        for (int i = 0; i < 16; i++) begin
            set2(2'b11, i, i);
            #1;
            chk($sformatf("sweep cam_we %0d", i), 32'(we2), 32'd3);
            tick();
        end
        set2(2'b00, 0, 0);
        chk("sweep last-word cycle state", 32'(state2), 32'd1);
        chk("sweep last-word cycle new", 32'(new2), 32'd0);
        tick();
        chk("sweep process state", 32'(state2), 32'd2);
        chk("sweep new_frame pulse", 32'(new2), 32'd1);
        chk("sweep reading low", 32'(read2), 32'd0);
        chk("sweep cam_we gated", 32'(we2), 32'd0);
        tick();
        chk("sweep new_frame single", 32'(new2), 32'd0);
        chk("sweep still process", 32'(state2), 32'd2);
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        chk("sweep done state", 32'(state2), 32'd3);
        chk("sweep done reading", 32'(read2), 32'd1);
        chk("sweep done count", 32'(cnt2), 32'd1);
        tick();
        chk("sweep rerun collect", 32'(state2), 32'd1);
        chk("sweep reading held", 32'(read2), 32'd1);

        // Camera 1 starts mid-frame at address 5; pacing drops mid-frame.
        for (int i = 0; i < 27; i++) begin
            if (i == 5) pacing2 = 1'b0;
            set2({1'b1, i < 16}, i % 16, (5 + i) % 16);
            chk($sformatf("offset no new %0d", i), 32'(new2), 32'd0);
            chk($sformatf("offset collect %0d", i), 32'(state2), 32'd1);
            tick();
        end
        set2(2'b00, 0, 0);
        chk("offset finish cycle state", 32'(state2), 32'd1);
        tick();
        chk("offset process state", 32'(state2), 32'd2);
        chk("offset new_frame", 32'(new2), 32'd1);
        chk("offset reading low", 32'(read2), 32'd0);
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        chk("offset done count", 32'(cnt2), 32'd2);
        tick();
        chk("offset pacing off idle", 32'(state2), 32'd0);
        tick();
        chk("offset reading held", 32'(read2), 32'd1);

        // Single shot, with frame_done arriving after 10 PROCESS cycles.
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        chk("idle frame_done ignored", 32'(state2), 32'd0);
        ss2 = 1'b1;
        tick();
        ss2 = 1'b0;
        chk("single enter collect", 32'(state2), 32'd1);
        for (int i = 0; i < 16; i++) begin
            set2(2'b11, i, i);
            tick();
        end
        set2(2'b00, 0, 0);
        tick();
        chk("single process", 32'(state2), 32'd2);
        chk("single new_frame", 32'(new2), 32'd1);
        ss2 = 1'b1;
        tick();
        ss2 = 1'b0;
        chk("single ss ignored in process", 32'(state2), 32'd2);
        for (int i = 0; i < 8; i++) tick();
        chk("single still process", 32'(state2), 32'd2);
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        chk("single done state", 32'(state2), 32'd3);
        chk("single done count", 32'(cnt2), 32'd1);
        tick();
        chk("single back to idle", 32'(state2), 32'd0);
        chk("single reading held", 32'(read2), 32'd1);
        tick();
        tick();
        chk("single stays idle", 32'(state2), 32'd0);
        chk("single reading still held", 32'(read2), 32'd1);
        chk("single count", 32'(cnt2), 32'd1);

        // Reset in the first PROCESS cycle.
        pacing2 = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            set2(2'b11, i, i);
            tick();
        end
        tick();
        chk("rst pre process", 32'(state2), 32'd2);
        rst2 = 1'b1; pacing2 = 1'b0; set2(2'b11, 4, 4);
        tick();
        chk("rst state", 32'(state2), 32'd0);
        chk("rst new_frame", 32'(new2), 32'd0);
        chk("rst reading", 32'(read2), 32'd0);
        chk("rst count", 32'(cnt2), 32'd0);
        chk("rst cam_we", 32'(we2), 32'd0);
        chk("rst timeout", 32'(to2), 32'd0);
        rst2 = 1'b0; done2 = 1'b1;
        tick();
        done2 = 1'b0;
        tick();
        chk("rst frame_done ignored state", 32'(state2), 32'd0);
        chk("rst frame_done ignored count", 32'(cnt2), 32'd0);
        set2(2'b00, 0, 0);

        // Four cameras, camera 3 lags by four words.
        pacing4 = 1'b1;
        tick();
        chk("cam4 collect", 32'(state4), 32'd1);
        for (int i = 0; i < 20; i++) begin
            int a0, a3;
            a0 = (i < 16) ? i : 0;
            a3 = (i >= 4) ? i - 4 : 0;
            wea4  = {i >= 4, i < 16, i < 16, i < 16};
            addr4 = {AW'(a3), AW'(a0), AW'(a0), AW'(a0)};
            chk($sformatf("cam4 no new %0d", i), 32'(new4), 32'd0);
            chk($sformatf("cam4 collect %0d", i), 32'(state4), 32'd1);
            tick();
        end
        wea4 = '0; addr4 = '0;
        chk("cam4 finish cycle", 32'(state4), 32'd1);
        tick();
        chk("cam4 process", 32'(state4), 32'd2);
        chk("cam4 new_frame", 32'(new4), 32'd1);
        pacing4 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter NUM_CAMS, default 2, number of camera channels (1..4).
REQ-002 SHALL have parameter FRAME_WORDS, default 12800, BRAM words per captured frame.
REQ-003 SHALL have parameter ADDR_W, default 17, camera write-address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4000000, max clk_in cycles allowed in COLLECT.
REQ-005 SHALL have port clk_in  input  1  single clock for all logic.
REQ-006 SHALL have port rst_in  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port pacing_in  input  1  continuous-run enable.
REQ-008 SHALL have port single_shot_in  input  1  one-cycle pulse requesting exactly one frame from IDLE.
REQ-009 SHALL have port cam_wea_in  input  NUM_CAMS  per-camera pixel-write strobe.
REQ-010 SHALL have port cam_addr_in  input  NUM_CAMS*ADDR_W  per-camera write address; camera k at bits [k*ADDR_W +: ADDR_W].
REQ-011 SHALL have port frame_done_in  input  1  processing-complete pulse from the matcher.
REQ-012 SHALL have port cam_we_out  output  NUM_CAMS  gated write enables to frame BRAMs.
REQ-013 SHALL have port new_frame_out  output  1  one-cycle start pulse to the matcher.
REQ-014 SHALL have port reading_out  output  1  result BRAM readable.
REQ-015 SHALL have port state_out  output  2  encoded state (IDLE=0, COLLECT=1, PROCESS=2, DONE=3).
REQ-016 SHALL have port frame_count_out  output  16  completed frames, wraps 0xFFFF->0.
REQ-017 SHALL have port timeout_out  output  1  one-cycle pulse on collection timeout.

Function
REQ-018 SHALL set cam_we_out[k] = cam_wea_in[k] combinationally while state is COLLECT, else 0.
REQ-019 SHALL, in IDLE, enter COLLECT next cycle if pacing_in or single_shot_in is 1; latch single_shot mode when only single_shot_in is 1.
REQ-020 SHALL, in COLLECT, set started[k] when cam_wea_in[k]=1 and address k equals 0.
REQ-021 SHALL, in COLLECT, set finished[k] when started[k]=1, cam_wea_in[k]=1 and address k equals FRAME_WORDS-1; started and finished set in same cycle on address 0 SHALL NOT mark finished.
REQ-022 SHALL, on the cycle all finished[] bits are 1, go to PROCESS, assert new_frame_out for exactly the next cycle, deassert reading_out, and clear all started/finished flags.
REQ-023 SHALL stay in PROCESS until frame_done_in=1, then go to DONE; frame_done_in outside PROCESS SHALL be ignored.
REQ-024 SHALL, in DONE (one cycle), set reading_out=1, increment frame_count_out, and go to COLLECT if pacing_in=1 and not single-shot mode, else IDLE.
REQ-025 SHALL hold reading_out=1 until the next new_frame_out.
REQ-026 SHALL, on pacing_in falling during COLLECT, complete the current frame (no abort).
REQ-027 SHALL treat single_shot_in outside IDLE as ignored.

Reset
REQ-028 SHALL, on rst_in=1 at a clk_in edge, force state IDLE, clear all flags, counters, mode latch; outputs cam_we_out=0, new_frame_out=0, reading_out=0, state_out=0, frame_count_out=0, timeout_out=0.
REQ-029 SHALL have rst_in take priority over every other input, including mid-COLLECT and mid-PROCESS.

Configuration
REQ-030 SHALL, with macro CAPTURE_SEQ_TIMEOUT_EN defined, count cycles in COLLECT (cleared on entry); on reaching TIMEOUT_CYCLES, clear started/finished, restart the count, stay in COLLECT, pulse timeout_out one cycle.
REQ-031 SHALL, without CAPTURE_SEQ_TIMEOUT_EN, omit the counter and tie timeout_out to 0.

Verification
REQ-032 Bench SHALL check: NUM_CAMS=2, FRAME_WORDS=16, pacing_in=1, both cameras sweep 0..15 -> one new_frame_out pulse, state_out=2.
REQ-033 Bench SHALL check: camera 1 starts at address 5 -> no finish until it wraps through 0..15; new_frame_out only after full sweep.
REQ-034 Bench SHALL check: single_shot_in pulse, pacing_in=0, frame_done_in after 10 cycles -> state 3 then 0, frame_count_out=1, reading_out=1 held.
REQ-035 Bench SHALL check: TIMEOUT_EN, TIMEOUT_CYCLES=50, camera 0 idle -> timeout_out pulse at cycle 50 of COLLECT, flags cleared.
REQ-036 Bench SHALL check: rst_in asserted mid-PROCESS -> next cycle all outputs 0, later frame_done_in ignored.
REQ-037 Bench SHALL check: NUM_CAMS=4, camera 3 finishes last -> new_frame_out only after camera 3's word FRAME_WORDS-1.
